// File: rtl/data_sram_responder.sv
// data_sram_responder: word-organised data SRAM behind a req/addr_ok,
// data_ok handshake. Accepted requests travel through a small in-order
// queue and are answered exactly RESP_LAT cycles after acceptance.
module data_sram_responder #(
  parameter int MEM_AW   = 10,
  parameter int RESP_LAT = 2,
  parameter int QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
  localparam logic [2:0]    LAT   = 3'(RESP_LAT);

  // Backing store; contents are never reset.
  logic [31:0] mem [2**MEM_AW];

  // Response queue slots.
  logic [QDEPTH-1:0] q_valid;
  logic              q_is_write [QDEPTH];
  logic [31:0]       q_data     [QDEPTH];
  logic [2:0]        q_cnt      [QDEPTH];

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic [MEM_AW-1:0] word_idx;
  logic              accept;
  logic              respond;
  logic              addr_unused_bits;

  // Byte offset and bits above the store size do not select a word.
  assign word_idx         = addr[MEM_AW+1:2];
  assign addr_unused_bits = ^{addr[31:MEM_AW+2], addr[1:0]};

  // Handshake depends only on registered occupancy, never on req.
  assign addr_ok = !reset && (count < QFULL);
  assign accept  = req && addr_ok;

  // The head entry answers in the cycle its countdown reaches one.
  assign respond = !reset && q_valid[head] && (q_cnt[head] == 3'd1);
  assign data_ok = respond;
  assign rdata   = (respond && !q_is_write[head]) ? q_data[head] : 32'd0;

  // Byte-masked write of an accepted store request.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Queue bookkeeping: age entries, retire the head, append new requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (q_valid[i] && (q_cnt[i] != 3'd0)) q_cnt[i] <= q_cnt[i] - 3'd1;
      end
      if (respond) begin
        q_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (accept) begin
        q_valid[tail]    <= 1'b1;
        q_is_write[tail] <= wr;
        q_data[tail]     <= wr ? 32'd0 : mem[word_idx];
        q_cnt[tail]      <= LAT;
        tail             <= tail + 1'b1;
      end
      case ({accept, respond})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning word-address width of the backing store (2^MEM_AW 32-bit words).
REQ-002 SHALL have parameter RESP_LAT, default 2, meaning the fixed request-to-response latency in cycles (legal range 1..7).
REQ-003 SHALL have parameter QDEPTH, default 2, meaning the maximum number of outstanding requests (legal values 2 or 4).
REQ-004 SHALL have port clk, input, 1, the clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, the reset; synchronous, active-high.
REQ-006 SHALL have port req, input, 1, meaning a request is valid this cycle.
REQ-007 SHALL have port wr, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port wstrb, input, 4, the per-byte write enables (bit i enables wdata[8i+7:8i]).
REQ-009 SHALL have port addr, input, 32, the byte address.
REQ-010 SHALL have port wdata, input, 32, the write data.
REQ-011 SHALL have port addr_ok, output, 1, meaning the request is accepted this cycle when req is also high.
REQ-012 SHALL have port data_ok, output, 1, a one-cycle response strobe.
REQ-013 SHALL have port rdata, output, 32, the read response data.

Function
REQ-014 SHALL accept a request in cycle c iff req && addr_ok in cycle c; a request with addr_ok low has no side effect.
REQ-015 SHALL drive addr_ok = !reset && (pending count < QDEPTH), from registered state only, with no combinational path from req.
REQ-016 SHALL derive the word index as addr[MEM_AW+1:2]; upper bits and addr[1:0] are ignored, so addresses wrap modulo the store size.
REQ-017 SHALL update, on an accepted write, only the wstrb-enabled bytes of the indexed word, at the end of cycle c; wstrb = 0 leaves memory unchanged but still produces a response.
REQ-018 SHALL capture, on an accepted read, the full indexed word at the end of cycle c, including any write accepted in an earlier cycle; byte/half extraction is the consumer's job.
REQ-019 SHALL enqueue each accepted request into an in-order response queue entry: {is_write, data, countdown = RESP_LAT}.
REQ-020 SHALL decrement the countdowns of all occupied entries every cycle, saturating at 0.
REQ-021 SHALL assert data_ok in cycle c+RESP_LAT for a request accepted in cycle c, for exactly one cycle per request, in acceptance order.
REQ-022 SHALL drive rdata = captured word during data_ok for a read, and 0 for a write; rdata = 0 whenever data_ok = 0.
REQ-023 SHALL free the head entry at the end of its data_ok cycle.
REQ-024 SHALL, when an accept and a response coincide, keep the pending count unchanged and write the queue slot and pointers consistently (pointers wrap modulo QDEPTH).
REQ-025 SHALL, when the queue is full, hold addr_ok low; addr_ok rises in the cycle after the head's data_ok.
REQ-026 SHALL sustain back-to-back accepts when QDEPTH >= RESP_LAT+1, and otherwise limit throughput to QDEPTH requests per RESP_LAT+1 cycles.

Reset
REQ-027 SHALL, during reset, clear the pending count, queue pointers and valid bits, and drive addr_ok = 0, data_ok = 0 and rdata = 0.
REQ-028 SHALL, on reset mid-operation, drop all pending responses: no data_ok for any request accepted before reset, while writes already accepted remain in memory.
REQ-029 SHALL leave memory contents unchanged by reset; initial contents are undefined until written.
REQ-030 SHALL drive addr_ok = 1 in the first cycle after reset deasserts.

Verification
REQ-031 SHALL pass: write addr 0x10, wstrb 0xF, wdata 0x12345678, then read 0x10 -> read data_ok exactly RESP_LAT cycles after its accept, rdata 0x12345678; the write's data_ok carries rdata 0.
REQ-032 SHALL pass: after REQ-031, write 0x11 with wstrb 0x2 and wdata 0x0000AB00, then read 0x10 -> rdata 0x1234AB78.
REQ-033 SHALL pass: RESP_LAT = 2, QDEPTH = 2, req held high with reads to 0x0, 0x4, 0x8 -> first two accepted in consecutive cycles, addr_ok low one cycle, third accepted after the first data_ok, three data_ok in order.
REQ-034 SHALL pass: MEM_AW = 10, write 0x00001000 with 0xDEADBEEF, read 0x0 -> rdata 0xDEADBEEF (wrap).
REQ-035 SHALL pass: accept two reads, assert reset one cycle before the first response -> no data_ok afterwards, count 0, addr_ok = 1 the cycle after reset falls.
REQ-036 SHALL pass: req with addr_ok low while full, wr = 1 -> memory unchanged and no extra response.
